// File: rtl/sm83_pkg.sv
// Shared types for the SM83 fetch/decode queue: length classes, FSM states, descriptor layout.
// The LOCK state exists only when SM83_FETCH_ILLEGAL_TRAP_EN is defined.
package sm83_pkg;

    localparam logic [7:0] OpcCb = 8'hCB;

    typedef enum logic [1:0] {
        Len1,
        Len2,
        Len3,
        LenPrefix
    } len_class_e;

    typedef enum logic [2:0] {
        StOpc,
        StCb,
        StImmLo,
        StImmHi
`ifdef SM83_FETCH_ILLEGAL_TRAP_EN
        ,
        StLock
`endif
    } state_e;

    typedef struct packed {
        logic [7:0]  opcode;
        logic        bank_cb;
        logic [1:0]  len;
        logic [15:0] imm;
        logic        illegal;
    } desc_t;

    function automatic len_class_e len_class(input logic [7:0] op);
        logic ld_imm8;
        // LD r,d8 and ALU A,d8 rows share the low-3-bit pattern 110
        ld_imm8 = (op[7:6] == 2'b00 || op[7:6] == 2'b11) && (op[2:0] == 3'b110);
        if (op == OpcCb) return LenPrefix;
        case (op)
            8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hE0, 8'hF0, 8'hE8, 8'hF8:                      return Len2;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
            8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC,
            8'hEA, 8'hFA:                                    return Len3;
            default:                                         return ld_imm8 ? Len2 : Len1;
        endcase
    endfunction

    function automatic logic is_illegal(input logic [7:0] op);
        case (op)
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sm83_desc_fifo.sv
// Descriptor FIFO with wrap-around pointers; head reads as zero while empty.
module sm83_desc_fifo
    import sm83_pkg::*;
#(
    parameter int unsigned Depth = 2
) (
    input  logic  clk_i,
    input  logic  nreset_i,
    input  logic  flush_i,
    input  logic  push_i,
    input  logic  pop_i,
    input  desc_t wdata_i,
    output desc_t rdata_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(Depth - 1);

    desc_t           mem_q [Depth];
    logic [PtrW-1:0] rd_q, wr_q;
    logic [CntW-1:0] cnt_q;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastIdx) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (!nreset_i || flush_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= ptr_inc(wr_q);
            if (pop_i)  rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= wdata_i;
    end

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CntW'(Depth));
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/sm83_fetch_decode.sv
// SM83 byte-stream instruction assembler feeding a descriptor queue.
// Define SM83_FETCH_ILLEGAL_TRAP_EN to flag illegal opcodes and lock the input until flush/reset.
module sm83_fetch_decode
    import sm83_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 2,
    parameter int unsigned IMM_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_opcode,
    output logic                 out_bank_cb,
    output logic [1:0]           out_len,
    output logic [IMM_WIDTH-1:0] out_imm,
    output logic                 out_illegal,
    output logic                 busy
);

    state_e      state_q, state_d;
    logic [7:0]  opc_q, opc_d;
    logic [15:0] imm_q, imm_d;
    logic        two_left_q, two_left_d;

    logic  q_full, q_empty, accept, pop, push;
    desc_t push_desc, head;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q    <= StOpc;
            opc_q      <= '0;
            imm_q      <= '0;
            two_left_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opc_q      <= opc_d;
            imm_q      <= imm_d;
            two_left_q <= two_left_d;
        end
    end

`ifdef SM83_FETCH_ILLEGAL_TRAP_EN
    assign in_ready = !q_full && (state_q != StLock);
`else
    assign in_ready = !q_full;
`endif
    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready && !flush;
    assign busy   = (state_q != StOpc);

    always_comb begin
        state_d    = state_q;
        opc_d      = opc_q;
        imm_d      = imm_q;
        two_left_d = two_left_q;
        push       = 1'b0;
        push_desc  = '0;
        if (flush) begin
            state_d = StOpc;
            imm_d   = '0;
        end else if (accept) begin
            case (state_q)
                StOpc: begin
                    opc_d = in_data;
                    imm_d = '0;
`ifdef SM83_FETCH_ILLEGAL_TRAP_EN
                    if (is_illegal(in_data)) begin
                        push              = 1'b1;
                        push_desc.opcode  = in_data;
                        push_desc.len     = 2'd1;
                        push_desc.illegal = 1'b1;
                        state_d           = StLock;
                    end else
`endif
                    begin
                        case (len_class(in_data))
                            LenPrefix: state_d = StCb;
                            Len2: begin
                                state_d    = StImmLo;
                                two_left_d = 1'b0;
                            end
                            Len3: begin
                                state_d    = StImmLo;
                                two_left_d = 1'b1;
                            end
                            default: begin
                                push             = 1'b1;
                                push_desc.opcode = in_data;
                                push_desc.len    = 2'd1;
                            end
                        endcase
                    end
                end
                StCb: begin
                    push              = 1'b1;
                    push_desc.opcode  = in_data;
                    push_desc.bank_cb = 1'b1;
                    push_desc.len     = 2'd2;
                    state_d           = StOpc;
                end
                StImmLo: begin
                    imm_d[7:0] = in_data;
                    if (!two_left_q) begin
                        push             = 1'b1;
                        push_desc.opcode = opc_q;
                        push_desc.len    = 2'd2;
                        push_desc.imm    = {8'h00, in_data};
                        state_d          = StOpc;
                    end else begin
                        state_d = StImmHi;
                    end
                end
                StImmHi: begin
                    imm_d[15:8]      = in_data;
                    push             = 1'b1;
                    push_desc.opcode = opc_q;
                    push_desc.len    = 2'd3;
                    push_desc.imm    = {in_data, imm_q[7:0]};
                    state_d          = StOpc;
                end
                default: ;
            endcase
        end
    end

    sm83_desc_fifo #(
        .Depth (QUEUE_DEPTH)
    ) u_fifo (
        .clk_i    (clk),
        .nreset_i (nreset),
        .flush_i  (flush),
        .push_i   (push),
        .pop_i    (pop),
        .wdata_i  (push_desc),
        .rdata_o  (head),
        .full_o   (q_full),
        .empty_o  (q_empty)
    );

    assign out_valid   = !q_empty;
    assign out_opcode  = head.opcode;
    assign out_bank_cb = head.bank_cb;
    assign out_len     = head.len;
    assign out_imm     = IMM_WIDTH'(head.imm);
    // Only ever set when the illegal trap is compiled in.
    assign out_illegal = head.illegal;

endmodule
